// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: state/word types, round constants and the S-box.
// Used by the AddRoundKey stage, the key schedule and SubBytes.
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  word_t;

    localparam int NR = 10;

    // Index = round number; entries 0 and 11..15 are unused padding
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/key_expand_step.sv
// One combinational AES-128 key schedule step: next round key from the current
// round key and the round constant.
module key_expand_step
    import aes_pkg::*;
(
    input  state_t     rk_in,
    input  logic [7:0] rcon,
    output state_t     rk_out
);

    word_t w0, w1, w2, w3;
    word_t rot, t;
    word_t n0, n1, n2, n3;

    always_comb begin
        w0  = rk_in[127:96];
        w1  = rk_in[95:64];
        w2  = rk_in[63:32];
        w3  = rk_in[31:0];
        rot = {w3[23:0], w3[31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {rcon, 24'h000000};
        n0  = w0 ^ t;
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
        rk_out = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/add_round_key_stage.sv
// AddRoundKey stage of the iterative AES-128 datapath: XORs each round state with
// an on-the-fly round key and registers the result behind a valid/ready handshake.
module add_round_key_stage #(
    parameter int NR = 10,
    parameter int KW = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_load,
    input  logic [KW-1:0] key_in,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [KW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [KW-1:0] out_data,
    output logic [3:0]    out_round,
    output logic          out_last
);

    import aes_pkg::*;

    logic [KW-1:0] ck;
    logic [KW-1:0] rk;
    logic [KW-1:0] rk_next;
    logic [3:0]    rnd;
    logic [3:0]    rcon_idx;
    logic [7:0]    rcon_sel;
    logic          key_ok;
    logic          accept;
    logic          rnd_last;

    // Single output register, no skid buffer: accept only if it is empty or draining
    assign in_ready = key_ok & ~key_load & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign rnd_last = (rnd == 4'(NR));

    always_comb begin
        rcon_idx = rnd + 4'd1;
        rcon_sel = rnd_last ? 8'h00 : RCON[rcon_idx];
    end

    key_expand_step u_key_expand_step (
        .rk_in  (rk),
        .rcon   (rcon_sel),
        .rk_out (rk_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ck     <= '0;
            rk     <= '0;
            rnd    <= '0;
            key_ok <= 1'b0;
        end else if (key_load) begin
            ck     <= key_in;
            rk     <= key_in;
            rnd    <= '0;
            key_ok <= 1'b1;
        end else if (accept) begin
            if (rnd_last) begin
                rk  <= ck;
                rnd <= '0;
            end else begin
                rk  <= rk_next;
                rnd <= rnd + 4'd1;
            end
        end
    end

    // A new accept overwrites the draining output in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_round <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data ^ rk;
            out_round <= rnd;
            out_last  <= rnd_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add_round_key_stage.sv
// Directed bench for add_round_key_stage using FIPS-197 key schedule vectors.
module tb_add_round_key_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_load;
    logic [127:0] key_in;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_round;
    logic         out_last;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

    logic [127:0] rk [11];

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
        logic [3:0]   rnd;
        logic         last;
    } vec_t;

    vec_t vecs [12];

    add_round_key_stage #(.NR(10), .KW(128)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_round (out_round),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_key_load(input logic [127:0] k);
        @(negedge clk);
        key_load = 1'b1;
        key_in   = k;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    // Offers one word and returns 1 ns after the accepting edge
    task automatic send(input logic [127:0] d);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rk[0]  = K1;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        vecs[0]  = '{128'h3243f6a8885a308d313198a2e0370734, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 4'd0, 1'b0};
        vecs[1]  = '{128'h046681e5e0cb199a48f8d37a2806264c, 128'ha49c7ff2689f352b6b5bea43026a5049, 4'd1, 1'b0};
        vecs[2]  = '{128'h0, rk[2], 4'd2, 1'b0};
        vecs[3]  = '{128'h0, rk[3], 4'd3, 1'b0};
        vecs[4]  = '{128'h0, rk[4], 4'd4, 1'b0};
        vecs[5]  = '{128'h0, rk[5], 4'd5, 1'b0};
        vecs[6]  = '{128'h0, rk[6], 4'd6, 1'b0};
        vecs[7]  = '{128'h0, rk[7], 4'd7, 1'b0};
        vecs[8]  = '{128'h0, rk[8], 4'd8, 1'b0};
        vecs[9]  = '{128'h0, rk[9], 4'd9, 1'b0};
        vecs[10] = '{128'he9317db5cb322c723d2e895faf090794, 128'h3925841d02dc09fbdc118597196a0b32, 4'd10, 1'b1};
        vecs[11] = '{128'hffffffffffffffffffffffffffffffff, ~K1, 4'd0, 1'b0};

        rst       = 1'b0;
        key_load  = 1'b0;
        key_in    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        #2;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_data",  out_data, 128'd0);
        chk("rst_out_round", 128'(out_round), 128'd0);
        chk("rst_out_last",  128'(out_last), 128'd0);
        chk("rst_in_ready",  128'(in_ready), 128'd0);

        @(negedge clk);
        rst = 1'b1;

        // No key yet: inputs ignored
        in_valid = 1'b1;
        in_data  = 128'h1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("nokey_in_ready_%0d", i), 128'(in_ready), 128'd0);
            chk($sformatf("nokey_out_valid_%0d", i), 128'(out_valid), 128'd0);
        end
        in_valid = 1'b0;

        do_key_load(K1);

        // Full block of 11 rounds plus the wrap back to round 0
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].din);
            chk($sformatf("vec%0d_valid", i), 128'(out_valid), 128'd1);
            chk($sformatf("vec%0d_data", i), out_data, vecs[i].dout);
            chk($sformatf("vec%0d_round", i), 128'(out_round), 128'(vecs[i].rnd));
            chk($sformatf("vec%0d_last", i), 128'(out_last), 128'(vecs[i].last));
        end
        @(posedge clk);
        #1;
        chk("drain_out_valid", 128'(out_valid), 128'd0);

        // Backpressure: output held, no round consumed, then back-to-back accepts
        do_key_load(K1);
        send(128'h0);
        chk("bp_first_data", out_data, rk[0]);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 128'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp_in_ready_%0d", i), 128'(in_ready), 128'd0);
            chk($sformatf("bp_data_%0d", i), out_data, rk[0]);
            chk($sformatf("bp_round_%0d", i), 128'(out_round), 128'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        chk("bp_r1_data", out_data, rk[1]);
        chk("bp_r1_round", 128'(out_round), 128'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_r2_valid", 128'(out_valid), 128'd1);
        chk("bp_r2_data", out_data, rk[2]);
        chk("bp_r2_round", 128'(out_round), 128'd2);
        @(posedge clk);
        #1;
        chk("bp_drained", 128'(out_valid), 128'd0);

        // Reload while an output is pending: output must survive
        out_ready = 1'b0;
        send(128'h0);
        chk("pend_data", out_data, rk[3]);
        @(negedge clk);
        key_load = 1'b1;
        key_in   = K2;
        @(posedge clk);
        #1;
        chk("pend_keep_valid", 128'(out_valid), 128'd1);
        chk("pend_keep_data", out_data, rk[3]);
        chk("pend_keep_round", 128'(out_round), 128'd3);
        @(negedge clk);
        key_load  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("pend_drained", 128'(out_valid), 128'd0);

        // key_load with in_valid in the same cycle: no accept
        @(negedge clk);
        key_load = 1'b1;
        key_in   = K2;
        in_valid = 1'b1;
        in_data  = 128'h0;
        #1;
        chk("kl_in_ready", 128'(in_ready), 128'd0);
        @(posedge clk);
        #1;
        chk("kl_no_accept", 128'(out_valid), 128'd0);
        @(negedge clk);
        key_load = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("kl_r0_valid", 128'(out_valid), 128'd1);
        chk("kl_r0_data", out_data, K2);
        chk("kl_r0_round", 128'(out_round), 128'd0);
        send(128'h0);
        chk("kl_r1_data", out_data, K2R1);
        chk("kl_r1_round", 128'(out_round), 128'd1);

        // Async reset mid-cycle at round 5
        do_key_load(K1);
        for (int i = 0; i < 6; i++) send(128'h0);
        chk("pre_rst_round", 128'(out_round), 128'd5);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'd0);
        chk("arst_out_data", out_data, 128'd0);
        chk("arst_out_round", 128'(out_round), 128'd0);
        chk("arst_in_ready", 128'(in_ready), 128'd0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 128'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("arst_hold_ready_%0d", i), 128'(in_ready), 128'd0);
        end
        in_valid = 1'b0;
        chk("arst_hold_valid", 128'(out_valid), 128'd0);
        do_key_load(K1);
        send(128'h0);
        chk("arst_reload_data", out_data, rk[0]);
        chk("arst_reload_round", 128'(out_round), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/add_round_key_stage.md
Name: add_round_key_stage

Overview:
- Downstream neighbour of MixColumns in the iterative AES-128 encryption datapath.
- Each round, takes the 128-bit state (MixColumns output; plaintext for round 0; ShiftRows output for round 10) and XORs it with the current round key.
- Registers the result and advances an on-the-fly key schedule, so no precomputed key storage is needed.
- Sits between the MixColumns/ShiftRows mux and the round-state register feeding SubBytes.

Parameters:
- NR, 10, number of AES rounds (AES-128 only; other values unsupported).
- KW, 128, key/state width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- key_load  in  1  pulse: capture key_in as cipher key, restart schedule.
- key_in  in  128  cipher key, FIPS-197 byte order, byte 0 at [127:120].
- in_valid  in  1  in_data valid.
- in_ready  out  1  stage can accept in_data this cycle.
- in_data  in  128  state to be keyed.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  128  in_data XOR round key.
- out_round  out  4  round index (0..10) of the key applied to out_data.
- out_last  out  1  high when out_round == NR.

Behaviour:
- Reset (rst low, async): out_valid=0, out_data=0, out_round=0, out_last=0, round counter rnd=0, rk=0, cipher key reg=0. in_ready is 0 while no key has been loaded (key_ok=0).
- key_load=1: ck<=key_in, rk<=key_in, rnd<=0, key_ok<=1.
  - in_ready is forced 0 in that cycle.
  - A pending output (out_valid=1) is kept intact.
- in_ready = key_ok & ~key_load & (~out_valid | out_ready). This is a single output register with no skid buffer.
- Accept (in_valid & in_ready):
  - Next cycle: out_data = in_data ^ rk, out_round = rnd, out_last = (rnd==NR), out_valid=1. Latency is exactly 1 cycle.
  - Same edge, when rnd<NR: rk <= expand(rk, rcon[rnd+1]), rnd <= rnd+1.
  - Same edge, when rnd==NR: rk <= ck, rnd <= 0 (wrap, ready for next block without reload).
- out_valid clears on out_ready when no new accept occurs in that cycle. Simultaneous drain and accept: the new output replaces the old one; out_valid stays 1.
- Throughput: 1 round per cycle when out_ready is held high.
- expand(w0..w3, rc) is the FIPS-197 key step:
  - t = SubWord(RotWord(w3)) ^ {rc,24'h0}
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- in_valid while key_ok=0 is ignored; no state change.
- Async reset mid-block discards all progress; a key must be reloaded.
- in_valid held with in_ready low: in_data must be held stable by the upstream (standard valid/ready rule).

Decomposition:
- Shared package aes_pkg holds:
  - typedefs state_t (logic [127:0]) and word_t (logic [31:0]);
  - constants NR=10 and the RCON array;
  - the S-box function sbox(byte), shared with SubBytes.
- One natural sub-module: key_expand_step, purely combinational (rk_in, rcon -> rk_out, using 4 sbox calls).
- The stage itself holds the handshake, rnd counter, rk/ck registers and the output register.

Test Plan:
- FIPS-197 App. B round 0: key_load key=2b7e151628aed2a6abf7158809cf4f3c, then in_data=3243f6a8885a308d313198a2e0370734 -> next cycle out_data=193de3bea0f4e22b9ac68d2ae9f84808, out_round=0.
- Round 1: in_data=046681e5e0cb199a48f8d37a2806264c -> out_data=a49c7ff2689f352b6b5bea43026a5049, out_round=1 (rk=a0fafe1788542cb123a339392a6c7605).
- Round 10 and wrap: drive 9 more inputs, the last being e9317db5cb322c723d2e895faf090794 -> out_data=3925841d02dc09fbdc118597196a0b32, out_last=1. The next input is XORed with 2b7e1516...4f3c and reports out_round=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_data stable, rnd unchanged. Release -> accepts continue with no lost or duplicated round.
- key_load with in_valid=1 in the same cycle -> no accept that cycle. After a mid-block reload, the next output uses round-0 key = new key_in, out_round=0.
- Async reset asserted mid-cycle at round 5 -> outputs zero immediately. in_ready stays 0 until key_load.
